// File: rtl/ascii_pkg.sv
// Shared constants for the ASCII operand parser: character codes and FSM state encoding.
package ascii_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    StAFirst,
    StAMore,
    StBFirst,
    StBMore,
    StOut,
    StErr
  } state_e;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational classifier for one ASCII character; anything not flagged is invalid.
module ascii_char_class
  import ascii_pkg::*;
(
  input  logic [7:0] ch_i,
  output logic       is_digit_o,
  output logic       is_plus_o,
  output logic       is_eq_o,
  output logic       is_space_o
);

  assign is_digit_o = (ch_i >= CH_0) && (ch_i <= CH_9);
  assign is_plus_o  = (ch_i == CH_PLUS);
  assign is_eq_o    = (ch_i == CH_EQ);
  assign is_space_o = (ch_i == CH_SPACE);

endmodule

// File: rtl/ascii_operand_parser.sv
// Parses "A+B=" character streams into a pair of packed-BCD operands with a valid/ready output
// handshake and a one-cycle error pulse on malformed input.
module ascii_operand_parser
  import ascii_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    in_valid_i,
  input  logic [7:0]              in_data_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [4*MAX_DIGITS-1:0] op_a_o,
  output logic [4*MAX_DIGITS-1:0] op_b_o,
  output logic                    err_o
);

  localparam int unsigned W    = 4 * MAX_DIGITS;
  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_DIGITS);

  state_e          state_q, state_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic is_digit, is_plus, is_eq, is_space;
  logic accept;

  ascii_char_class u_char_class (
    .ch_i       (in_data_i),
    .is_digit_o (is_digit),
    .is_plus_o  (is_plus),
    .is_eq_o    (is_eq),
    .is_space_o (is_space)
  );

  // Shift form also covers MAX_DIGITS=1, where a part-select would be empty.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] op, input logic [3:0] d);
    return (op << 4) | W'(d);
  endfunction

  assign in_ready_o  = (state_q == StAFirst) || (state_q == StAMore) ||
                       (state_q == StBFirst) || (state_q == StBMore);
  assign out_valid_o = (state_q == StOut);
  assign err_o       = (state_q == StErr);
  assign accept      = in_valid_i && in_ready_o;
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StAFirst: begin
        if (accept) begin
          if (is_digit) begin
            op_a_d  = shift_in(op_a_q, in_data_i[3:0]);
            cnt_d   = CntW'(1);
            state_d = StAMore;
          end else if (!is_space) begin
            state_d = StErr;
          end
        end
      end
      StAMore: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q < CntMax) begin
              op_a_d = shift_in(op_a_q, in_data_i[3:0]);
              cnt_d  = cnt_q + CntW'(1);
            end else begin
              state_d = StErr;
            end
          end else if (is_plus) begin
            cnt_d   = '0;
            state_d = StBFirst;
          end else if (!is_space) begin
            state_d = StErr;
          end
        end
      end
      StBFirst: begin
        if (accept) begin
          if (is_digit) begin
            op_b_d  = shift_in(op_b_q, in_data_i[3:0]);
            cnt_d   = CntW'(1);
            state_d = StBMore;
          end else if (!is_space) begin
            state_d = StErr;
          end
        end
      end
      StBMore: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q < CntMax) begin
              op_b_d = shift_in(op_b_q, in_data_i[3:0]);
              cnt_d  = cnt_q + CntW'(1);
            end else begin
              state_d = StErr;
            end
          end else if (is_eq) begin
            state_d = StOut;
          end else if (!is_space) begin
            state_d = StErr;
          end
        end
      end
      StOut: begin
        if (out_ready_i) begin
          op_a_d  = '0;
          op_b_d  = '0;
          cnt_d   = '0;
          state_d = StAFirst;
        end
      end
      StErr: begin
        op_a_d  = '0;
        op_b_d  = '0;
        cnt_d   = '0;
        state_d = StAFirst;
      end
      default: begin
        op_a_d  = '0;
        op_b_d  = '0;
        cnt_d   = '0;
        state_d = StAFirst;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAFirst;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Scoreboard bench: accepted characters feed a string-level parser model that queues expected
// operand pairs and error pulses; a monitor compares them against the DUT outputs.
module tb_ascii_operand_parser;

  localparam int unsigned N = 2;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, err;
  logic [W-1:0] op_a, op_b;

  ascii_operand_parser #(.MAX_DIGITS(N)) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .op_a_o      (op_a),
    .op_b_o      (op_b),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit           is_err;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           at;
  } ev_t;

  ev_t          exp_q[$];
  byte unsigned mbuf[$];   // non-space characters of the expression in progress
  bit           hold = 1'b0;
  logic [W-1:0] ha = '0, hb = '0;
  bit           rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_dig(input byte unsigned c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // 0 = valid prefix, 1 = complete "A+B=", 2 = malformed. a/b are the operands seen so far.
  function automatic int eval_expr(input byte unsigned s[$], output logic [W-1:0] a,
                                   output logic [W-1:0] b);
    int i = 0;
    int na = 0;
    int nb = 0;
    a = '0;
    b = '0;
    while (i < s.size() && is_dig(s[i])) begin
      a = (a << 4) | W'(s[i] - 8'd48);
      na++;
      i++;
    end
    if (na > N) return 2;
    if (i == s.size()) return 0;
    if (s[i] != 8'h2B || na == 0) return 2;
    i++;
    while (i < s.size() && is_dig(s[i])) begin
      b = (b << 4) | W'(s[i] - 8'd48);
      nb++;
      i++;
    end
    if (nb > N) return 2;
    if (i == s.size()) return 0;
    if (s[i] != 8'h3D || nb == 0 || i + 1 != s.size()) return 2;
    return 1;
  endfunction

  task automatic model_accept(input byte unsigned c, input int at);
    logic [W-1:0] a, b;
    int r;
    ev_t e;
    if (c == 8'h20) return;
    mbuf.push_back(c);
    r = eval_expr(mbuf, a, b);
    if (r != 0) begin
      e.is_err = (r == 2);
      e.a = (r == 2) ? '0 : a;
      e.b = (r == 2) ? '0 : b;
      e.at = at;
      exp_q.push_back(e);
      mbuf.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the character is accepted.
  task automatic send_char(input byte unsigned c);
    bit acc = 1'b0;
    int tries = 0;
    in_valid = 1'b1;
    in_data = c;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid = 1'b0;
    in_data = 8'($urandom);
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got no in_ready, expected acceptance of %0h", c);
    end else begin
      model_accept(c, cyc);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_op_b", 32'(op_b), 32'd0);
    exp_q.delete();
    mbuf.delete();
    hold = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (!hold) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("out_kind", 32'(e.is_err), 32'd0);
            check("out_latency", 32'(cyc), 32'(e.at));
            ha = e.a;
            hb = e.b;
          end
          hold = 1'b1;
        end
        check("out_op_a", 32'(op_a), 32'(ha));
        check("out_op_b", 32'(op_b), 32'(hb));
        check("out_in_ready", 32'(in_ready), 32'd0);
        check("out_err", 32'(err), 32'd0);
        if (out_ready) hold = 1'b0;
      end else if (err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_err", 32'(err), 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("err_kind", 32'(e.is_err), 32'd1);
          check("err_latency", 32'(cyc), 32'(e.at));
        end
        check("err_in_ready", 32'(in_ready), 32'd0);
      end else begin
        logic [W-1:0] pa, pb;
        void'(eval_expr(mbuf, pa, pb));
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("partial_op_a", 32'(op_a), 32'(pa));
        check("partial_op_b", 32'(op_b), 32'(pb));
        hold = 1'b0;
      end
    end
  end

  function automatic byte unsigned rand_digit();
    return 8'(8'h30 + $urandom_range(0, 9));
  endfunction

  task automatic send_spaces();
    if ($urandom_range(0, 3) == 0) send_char(8'h20);
  endtask

  task automatic send_good_expr();
    int na = $urandom_range(1, N);
    int nb = $urandom_range(1, N);
    send_spaces();
    for (int i = 0; i < na; i++) send_char(rand_digit());
    send_spaces();
    send_char(8'h2B);
    send_spaces();
    for (int i = 0; i < nb; i++) send_char(rand_digit());
    send_spaces();
    send_char(8'h3D);
  endtask

  task automatic send_rand_char();
    case ($urandom_range(0, 9))
      5: send_char(8'h20);
      6: send_char(8'h2B);
      7: send_char(8'h3D);
      8: send_char(8'($urandom));
      default: send_char(rand_digit());
    endcase
  endtask

  initial begin
    out_ready = 1'b1;
    #1;
    check("por_in_ready", 32'(in_ready), 32'd1);
    check("por_out_valid", 32'(out_valid), 32'd0);
    check("por_err", 32'(err), 32'd0);
    check("por_op_a", 32'(op_a), 32'd0);
    check("por_op_b", 32'(op_b), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    send_str("12+7=");
    idle(3);

    out_ready = 1'b0;
    send_str("3+45=");
    idle(5);
    out_ready = 1'b1;
    idle(3);

    send_str("123+");
    send_str("4+5=");
    idle(2);

    send_str("9+");
    send_char(8'h41);
    idle(2);

    send_str(" 8 + 6 =");
    idle(2);
    send_str("+5=");
    send_str("5==");
    idle(3);

    send_str("56+7");
    async_reset();
    send_str("1+1=");
    idle(3);

    out_ready = 1'b0;
    send_str("2+3=");
    idle(2);
    async_reset();
    out_ready = 1'b1;
    idle(3);
    send_str("6+6=");
    idle(3);

    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) send_good_expr();
      else send_rand_char();
    end

    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(10);
    check("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ascii_operand_parser.md
ASCII_OPERAND_PARSER -- requirements
Module: ascii_operand_parser

Interface
REQ-001 Parameter MAX_DIGITS, default 2, max decimal digits per operand (1..4).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_n  input  1  asynchronous, active-low reset.
REQ-004 IN_VALID  input  1  IN_DATA holds a character this cycle.
REQ-005 IN_DATA  input  8  ASCII character.
REQ-006 IN_READY  output  1  parser accepts a character this cycle.
REQ-007 OUT_VALID  output  1  OP_A/OP_B hold a complete operand pair.
REQ-008 OUT_READY  input  1  downstream adder consumes the pair.
REQ-009 OP_A  output  4*MAX_DIGITS  operand A, packed BCD, least significant digit in [3:0].
REQ-010 OP_B  output  4*MAX_DIGITS  operand B, packed BCD, same packing.
REQ-011 ERR  output  1  one-cycle pulse on malformed input.

Function
REQ-012 A character SHALL be accepted only in a cycle with IN_VALID=1 and IN_READY=1; no other cycle changes state.
REQ-013 Classes: digit 0x30-0x39, PLUS 0x2B, EQ 0x3D, SPACE 0x20, all else INVALID.
REQ-014 States: A_FIRST, A_MORE, B_FIRST, B_MORE, OUT, ERR_ST.
REQ-015 A_FIRST: digit -> shift into OP_A, count=1, go A_MORE; SPACE -> stay; other -> ERR_ST.
REQ-016 A_MORE: digit with count<MAX_DIGITS -> shift, count+1; digit with count=MAX_DIGITS -> ERR_ST; PLUS -> B_FIRST, count=0; SPACE -> stay; EQ/INVALID -> ERR_ST.
REQ-017 B_FIRST/B_MORE: mirror A_FIRST/A_MORE on OP_B; B_MORE on EQ -> OUT; PLUS in any B state -> ERR_ST.
REQ-018 Digit shift SHALL be OP <= {OP[4*MAX_DIGITS-5:0], IN_DATA[3:0]}; upper digits of short operands read 0.
REQ-019 IN_READY SHALL be 1 in A_FIRST, A_MORE, B_FIRST, B_MORE and 0 in OUT and ERR_ST.
REQ-020 OUT_VALID SHALL be 1 exactly while in OUT, first asserted the cycle after EQ is accepted (latency 1).
REQ-021 OP_A/OP_B SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 OUT with OUT_READY=1 -> A_FIRST next cycle, OP_A, OP_B, count cleared.
REQ-023 ERR_ST SHALL last one cycle with ERR=1, then A_FIRST with OP_A, OP_B, count cleared; ERR=0 in all other states.
REQ-024 Offending character SHALL be consumed (IN_READY=1 in its cycle); no character accepted during ERR_ST.

Reset
REQ-025 RST_n=0 SHALL immediately force state A_FIRST, OP_A=0, OP_B=0, count=0, OUT_VALID=0, ERR=0, IN_READY=1, independent of CLK.
REQ-026 Reset mid-expression or during OUT SHALL discard the pending pair; no OUT_VALID until a new full expression.

Structure
REQ-027 Shared package ascii_pkg SHALL hold character constants (CH_0, CH_9, CH_PLUS, CH_EQ, CH_SPACE) and the state encoding.
REQ-028 Character decode SHALL be one combinational sub-module ascii_char_class (outputs is_digit, is_plus, is_eq, is_space); FSM and datapath in ascii_operand_parser.

Verification
REQ-029 Stream "12+7=" with IN_VALID held 1, OUT_READY=1 -> OUT_VALID one cycle after '=', OP_A=0x12, OP_B=0x07, ERR never 1.
REQ-030 "3+45=" with OUT_READY=0 for 5 cycles -> OUT_VALID, OP_A=0x03, OP_B=0x45 held stable, IN_READY=0 throughout; released one cycle after OUT_READY=1.
REQ-031 "123+" with MAX_DIGITS=2 -> ERR pulse one cycle after '3' accepted, then "4+5=" -> OP_A=0x04, OP_B=0x05.
REQ-032 Invalid byte 0x41 after "9+" -> single ERR pulse, IN_READY=0 for exactly one cycle, OP_A/OP_B return 0.
REQ-033 " 8 + 6 =" (spaces) -> OP_A=0x08, OP_B=0x06; "+5=" and "5==" -> ERR, no OUT_VALID.
REQ-034 RST_n pulsed low asynchronously mid-"56+7" -> outputs at reset values before next CLK edge; subsequent "1+1=" -> OP_A=0x01, OP_B=0x01.
